// File: rtl/snake_pkg.sv
// snake_pkg
// Shared types and constants for the snake renderer.
//   COORD_W       default pixel coordinate width
//   rgb12_t       4:4:4 colour word {r, g, b}
//   game_state_t  game-state FSM encoding (PLAY, WIN, LOSE)
//   WIN_RGB       overlay colour once the game is won
//   LOSE_RGB      overlay colour once the game is lost
package snake_pkg;

    localparam int COORD_W = 11;

    typedef logic [11:0] rgb12_t;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2
    } game_state_t;

    localparam rgb12_t WIN_RGB  = 12'h0F0;
    localparam rgb12_t LOSE_RGB = 12'hF00;

endpackage

// File: rtl/apple_sprite_rom.sv
// apple_sprite_rom
// Apple sprite texel store with a single-clock synchronous read.
// Build option SNAKE_RENDER_SPRITE_EN selects the vendor block RAM
// (blk_mem_gen_1, preloaded with the sprite image). Without it, a small
// procedurally generated apple keeps the module self-contained.
// Ports:
//   clk    in   pixel clock
//   addr   in   ADDR_W  texel address, row-major (row*SPR_W + col)
//   texel  out  12      texel colour one clock after addr; 12'h000 = transparent
module apple_sprite_rom
    import snake_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output rgb12_t            texel
);

`ifdef SNAKE_RENDER_SPRITE_EN

    blk_mem_gen_1 u_bram (
        .clka  (clk),
        .ena   (1'b1),
        .addra (addr),
        .douta (texel)
    );

`else

    // Red apple with a short brown stem and transparent rounded corners.
    function automatic rgb12_t texel_at(input logic [ADDR_W-1:0] a);
        int row;
        int col;
        row = int'(a) / SPR_W;
        col = int'(a) % SPR_W;
        if (col >= SPR_W/2 - 1 && col <= SPR_W/2 && row < SPR_H/8)
            return 12'h840;
        if ((row < SPR_H/8 || row >= SPR_H - SPR_H/8) &&
            (col < SPR_W/8 || col >= SPR_W - SPR_W/8))
            return 12'h000;
        return 12'hF00;
    endfunction

    always_ff @(posedge clk) begin
        texel <= texel_at(addr);
    end

`endif

endmodule

// File: rtl/snake_render.sv
// snake_render
// Three-stage pixel renderer for the snake game. Classifies each active
// pixel against the head, body segments, apple sprite and play-field
// border, and adds a blinking full-screen overlay once the game is won
// or lost. Latency is exactly 3 clocks, one pixel per clock.
// Build option SNAKE_RENDER_SPRITE_EN: the apple texel comes from
// apple_sprite_rom with 12'h000 transparent; otherwise the apple is a
// solid APPLE_RGB rectangle.
// Ports:
//   clk, rst                 pixel clock, synchronous active-low reset
//   snakepos_x/_y            MAX_SEG packed top-left corners, slice 0 = head
//   length                   active segment count (clamped to MAX_SEG)
//   applepos_x/_y            apple top-left corner
//   curr_x/_y, pix_valid     pixel being rendered and active-video flag
//   frame_start              one-clock pulse ahead of each frame
//   win, lose                game outcome levels
//   draw_r/_g/_b             colour, 3 clocks after the pixel
//   draw_valid               pix_valid aligned with the colour
module snake_render
    import snake_pkg::*;
#(
    parameter int     COORD_W      = snake_pkg::COORD_W,
    parameter int     MAX_SEG      = 23,
    parameter int     BLK_W        = 32,
    parameter int     BLK_H        = 32,
    parameter int     APPLE_W      = 32,
    parameter int     APPLE_H      = 32,
    parameter int     SCREEN_W     = 1440,
    parameter int     SCREEN_H     = 900,
    parameter int     BORDER       = 16,
    parameter int     BLINK_FRAMES = 30,
    parameter rgb12_t HEAD_RGB     = 12'hF00,
    parameter rgb12_t BODY_RGB     = 12'h0F0,
    parameter rgb12_t APPLE_RGB    = 12'hF00,
    parameter rgb12_t BORDER_RGB   = 12'hFFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MAX_SEG*COORD_W-1:0]   snakepos_x,
    input  logic [MAX_SEG*COORD_W-1:0]   snakepos_y,
    input  logic [$clog2(MAX_SEG+1)-1:0] length,
    input  logic [COORD_W-1:0]           applepos_x,
    input  logic [COORD_W-1:0]           applepos_y,
    input  logic [COORD_W-1:0]           curr_x,
    input  logic [COORD_W-1:0]           curr_y,
    input  logic                         pix_valid,
    input  logic                         frame_start,
    input  logic                         win,
    input  logic                         lose,
    output logic [3:0]                   draw_r,
    output logic [3:0]                   draw_g,
    output logic [3:0]                   draw_b,
    output logic                         draw_valid
);

    localparam int LEN_W = $clog2(MAX_SEG + 1);
    localparam int CW1   = COORD_W + 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW1-1:0] BORDER_LO = CW1'(BORDER);
    localparam logic [CW1-1:0] X_HI      = CW1'(SCREEN_W - BORDER);
    localparam logic [CW1-1:0] Y_HI      = CW1'(SCREEN_H - BORDER);

    // One extra bit keeps lo+size from wrapping near the coordinate limit.
    function automatic logic in_span(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input int                 size);
        logic [CW1-1:0] v1;
        logic [CW1-1:0] lo1;
        v1  = {1'b0, v};
        lo1 = {1'b0, lo};
        return (v1 >= lo1) && (v1 < lo1 + CW1'(size));
    endfunction

    // ---------------- Game-state FSM ----------------
    game_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PLAY;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Only frame_start moves the FSM, so every frame renders in one state.
    // The blink counter runs only while an overlay is showing, so the
    // entry frame always starts in the lit phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            case (state_q)
                PLAY: begin
                    if (lose)     state_d = LOSE;
                    else if (win) state_d = WIN;
                end
                WIN, LOSE: begin
                    if (BLINK_FRAMES != 0) begin
                        if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = PLAY;
            endcase
        end
    end

    // ---------------- Stage 1: hit tests ----------------
    logic [LEN_W-1:0]   eff_len;
    logic [MAX_SEG-1:0] seg_hit;
    logic               head_hit, body_hit, apple_hit, border_hit;

    assign eff_len = (length > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : length;

    for (genvar i = 0; i < MAX_SEG; i++) begin : g_seg
        assign seg_hit[i] = (LEN_W'(i) < eff_len)
            && in_span(curr_x, snakepos_x[i*COORD_W +: COORD_W], BLK_W)
            && in_span(curr_y, snakepos_y[i*COORD_W +: COORD_W], BLK_H);
    end

    assign head_hit   = seg_hit[0];
    assign body_hit   = |(seg_hit & ~MAX_SEG'(1));
    assign apple_hit  = in_span(curr_x, applepos_x, APPLE_W)
                     && in_span(curr_y, applepos_y, APPLE_H);
    assign border_hit = ({1'b0, curr_x} < BORDER_LO) || ({1'b0, curr_x} >= X_HI)
                     || ({1'b0, curr_y} < BORDER_LO) || ({1'b0, curr_y} >= Y_HI);

    logic        s1_valid, s1_head, s1_body, s1_apple, s1_border, s1_phase;
    game_state_t s1_state;

    // The FSM state and phase travel with the pixel so that a state change
    // can never tear a frame already in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_head   <= 1'b0;
            s1_body   <= 1'b0;
            s1_apple  <= 1'b0;
            s1_border <= 1'b0;
            s1_state  <= PLAY;
            s1_phase  <= 1'b1;
        end else begin
            s1_valid  <= pix_valid;
            s1_head   <= head_hit;
            s1_body   <= body_hit;
            s1_apple  <= apple_hit;
            s1_border <= border_hit;
            s1_state  <= state_q;
            s1_phase  <= phase_q;
        end
    end

    // ---------------- Apple texel source ----------------
    rgb12_t apple_texel;

`ifdef SNAKE_RENDER_SPRITE_EN
    localparam int ADDR_W = $clog2(APPLE_W * APPLE_H);

    logic [COORD_W-1:0] apple_dx, apple_dy;
    logic [ADDR_W-1:0]  apple_addr, s1_addr;

    // Address from the pixel offset, so any scan order reads the right texel.
    assign apple_dx   = curr_x - applepos_x;
    assign apple_dy   = curr_y - applepos_y;
    assign apple_addr = apple_hit
        ? (ADDR_W'(apple_dy) * ADDR_W'(APPLE_W) + ADDR_W'(apple_dx))
        : '0;

    always_ff @(posedge clk) begin
        if (!rst) s1_addr <= '0;
        else      s1_addr <= apple_addr;
    end

    apple_sprite_rom #(
        .ADDR_W (ADDR_W),
        .SPR_W  (APPLE_W),
        .SPR_H  (APPLE_H)
    ) u_rom (
        .clk   (clk),
        .addr  (s1_addr),
        .texel (apple_texel)
    );
`else
    assign apple_texel = APPLE_RGB;
`endif

    // ---------------- Stage 2: flags wait for ROM data ----------------
    logic        s2_valid, s2_head, s2_body, s2_apple, s2_border, s2_phase;
    game_state_t s2_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_head   <= 1'b0;
            s2_body   <= 1'b0;
            s2_apple  <= 1'b0;
            s2_border <= 1'b0;
            s2_state  <= PLAY;
            s2_phase  <= 1'b1;
        end else begin
            s2_valid  <= s1_valid;
            s2_head   <= s1_head;
            s2_body   <= s1_body;
            s2_apple  <= s1_apple;
            s2_border <= s1_border;
            s2_state  <= s1_state;
            s2_phase  <= s1_phase;
        end
    end

    // ---------------- Stage 3: colour mux ----------------
    rgb12_t mux_rgb, draw_rgb;

    // A transparent texel falls through to the border/background test.
    always_comb begin
        mux_rgb = '0;
        if (s2_valid) begin
            if (s2_state == WIN)                      mux_rgb = s2_phase ? WIN_RGB  : '0;
            else if (s2_state == LOSE)                mux_rgb = s2_phase ? LOSE_RGB : '0;
            else if (s2_head)                         mux_rgb = HEAD_RGB;
            else if (s2_body)                         mux_rgb = BODY_RGB;
            else if (s2_apple && apple_texel != '0)   mux_rgb = apple_texel;
            else if (s2_border)                       mux_rgb = BORDER_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            draw_rgb   <= '0;
            draw_valid <= 1'b0;
        end else begin
            draw_rgb   <= mux_rgb;
            draw_valid <= s2_valid;
        end
    end

    assign draw_r = draw_rgb[11:8];
    assign draw_g = draw_rgb[7:4];
    assign draw_b = draw_rgb[3:0];

endmodule

// File: tb/tb_snake_render.sv
// tb_snake_render
// Self-checking bench for snake_render (default build, solid apple,
// BLINK_FRAMES = 2). A frame-level model predicts every output cycle;
// directed probes pin hand-computed colours.
module tb_snake_render;

    localparam int CW    = 11;
    localparam int MS    = 23;
    localparam int LW    = 5;
    localparam int BLINK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [MS*CW-1:0] snakepos_x, snakepos_y;
    logic [LW-1:0]    length;
    logic [CW-1:0]    applepos_x, applepos_y, curr_x, curr_y;
    logic             pix_valid, frame_start, win, lose;
    logic [3:0]       draw_r, draw_g, draw_b;
    logic             draw_valid;

    int checks = 0;
    int errors = 0;

    snake_render #(.BLINK_FRAMES(BLINK)) dut (
        .clk         (clk),
        .rst         (rst),
        .snakepos_x  (snakepos_x),
        .snakepos_y  (snakepos_y),
        .length      (length),
        .applepos_x  (applepos_x),
        .applepos_y  (applepos_y),
        .curr_x      (curr_x),
        .curr_y      (curr_y),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .win         (win),
        .lose        (lose),
        .draw_r      (draw_r),
        .draw_g      (draw_g),
        .draw_b      (draw_b),
        .draw_valid  (draw_valid)
    );

    // ---------------- Behavioural model ----------------
    // Game mode: 0 = playing, 1 = won, 2 = lost. frames_in = frame pulses
    // seen since the overlay appeared (the entry pulse is frame 0).
    int m_mode;
    int m_frames_in;

    function automatic bit inRect(int x, int y, int px, int py, int w, int h);
        return x >= px && x < px + w && y >= py && y < py + h;
    endfunction

    function automatic int segX(int i);
        return int'(snakepos_x[i*CW +: CW]);
    endfunction

    function automatic int segY(int i);
        return int'(snakepos_y[i*CW +: CW]);
    endfunction

    // Returns {rgb, valid} for the pixel currently on the inputs.
    function automatic logic [12:0] modelPixel();
        int  x, y, n;
        bit  lit;
        x = int'(curr_x);
        y = int'(curr_y);
        if (!pix_valid) return 13'd0;
        if (m_mode != 0) begin
            lit = (BLINK == 0) || (((m_frames_in / BLINK) % 2) == 0);
            if (!lit) return {12'h000, 1'b1};
            return (m_mode == 1) ? {12'h0F0, 1'b1} : {12'hF00, 1'b1};
        end
        n = (int'(length) > MS) ? MS : int'(length);
        if (n >= 1 && inRect(x, y, segX(0), segY(0), 32, 32)) return {12'hF00, 1'b1};
        for (int i = 1; i < n; i++)
            if (inRect(x, y, segX(i), segY(i), 32, 32)) return {12'h0F0, 1'b1};
        if (inRect(x, y, int'(applepos_x), int'(applepos_y), 32, 32)) return {12'hF00, 1'b1};
        if (x < 16 || x >= 1424 || y < 16 || y >= 884) return {12'hFFF, 1'b1};
        return {12'h000, 1'b1};
    endfunction

    // ---------------- Compare process ----------------
    logic [12:0] expQ[$];
    bit          armed = 1'b0;

    initial begin
        logic [12:0] e;
        logic [11:0] act;
        forever begin
            @(posedge clk);
            if (!rst) begin
                armed = 1'b1;
                expQ.delete();
                repeat (3) expQ.push_back(13'd0);
                m_mode      = 0;
                m_frames_in = 0;
            end else if (armed) begin
                expQ.push_back(modelPixel());
                if (frame_start) begin
                    if (m_mode == 0) begin
                        if (lose)     m_mode = 2;
                        else if (win) m_mode = 1;
                        m_frames_in = 0;
                    end else begin
                        m_frames_in++;
                    end
                end
            end
            #1;
            if (armed && expQ.size() >= 3) begin
                e   = expQ.pop_front();
                act = {draw_r, draw_g, draw_b};
                checks++;
                if (act !== e[12:1] || draw_valid !== e[0]) begin
                    errors++;
                    $display("[TB] FAIL stream @%0t: got rgb=%03h valid=%0b, expected rgb=%03h valid=%0b",
                             $time, act, draw_valid, e[12:1], e[0]);
                end
            end
        end
    end

    // ---------------- Directed stimulus ----------------
    task automatic checkOutput(string name, logic [11:0] expRgb, logic expValid);
        logic [11:0] act;
        act = {draw_r, draw_g, draw_b};
        checks++;
        if (act !== expRgb || draw_valid !== expValid) begin
            errors++;
            $display("[TB] FAIL %s: got rgb=%03h valid=%0b, expected rgb=%03h valid=%0b",
                     name, act, draw_valid, expRgb, expValid);
        end
    endtask

    task automatic setSeg(int i, int x, int y);
        snakepos_x[i*CW +: CW] = CW'(x);
        snakepos_y[i*CW +: CW] = CW'(y);
    endtask

    // Hold one pixel and check the colour exactly 3 clocks later.
    task automatic applyStimulus(string name, int x, int y, bit v, logic [11:0] expRgb);
        @(negedge clk);
        curr_x      = CW'(x);
        curr_y      = CW'(y);
        pix_valid   = v;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput(name, expRgb, v);
    endtask

    task automatic pulseFrame();
        @(negedge clk);
        frame_start = 1'b1;
        pix_valid   = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        win         = 1'b0;
        lose        = 1'b0;
        length      = '0;
        curr_x      = '0;
        curr_y      = '0;
        applepos_x  = CW'(600);
        applepos_y  = CW'(600);
        for (int i = 0; i < MS; i++) setSeg(i, 1000, 700);

        repeat (3) @(negedge clk);
        checkOutput("reset_state", 12'h000, 1'b0);

        setSeg(0, 100, 100);
        length = LW'(1);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus("head_top_left",     100, 100, 1'b1, 12'hF00);
        applyStimulus("head_bottom_right", 131, 131, 1'b1, 12'hF00);
        applyStimulus("head_right_out",    132, 100, 1'b1, 12'h000);
        length = LW'(0);
        applyStimulus("length_zero",       110, 110, 1'b1, 12'h000);

        setSeg(1, 68, 100);
        setSeg(2, 36, 100);
        length = LW'(3);
        applyStimulus("seg2_len3",  40, 110, 1'b1, 12'h0F0);
        length = LW'(2);
        applyStimulus("seg2_len2",  40, 110, 1'b1, 12'h000);
        applyStimulus("seg1_len2",  70, 110, 1'b1, 12'h0F0);

        setSeg(0, 200, 200);
        applepos_x = CW'(200);
        applepos_y = CW'(200);
        length = LW'(1);
        applyStimulus("head_over_apple", 210, 210, 1'b1, 12'hF00);
        setSeg(0, 300, 300);
        setSeg(1, 200, 200);
        length = LW'(2);
        applyStimulus("body_over_apple", 210, 210, 1'b1, 12'h0F0);
        length = LW'(1);
        applyStimulus("apple_solid",     210, 210, 1'b1, 12'hF00);
        applyStimulus("apple_edge_in",   231, 231, 1'b1, 12'hF00);
        applyStimulus("apple_edge_out",  232, 210, 1'b1, 12'h000);

        applyStimulus("border_left",     5,    500, 1'b1, 12'hFFF);
        applyStimulus("border_right",    1424, 500, 1'b1, 12'hFFF);
        applyStimulus("inside_right",    1423, 500, 1'b1, 12'h000);
        applyStimulus("border_top",      700,  15,  1'b1, 12'hFFF);
        applyStimulus("inside_top",      700,  16,  1'b1, 12'h000);
        applyStimulus("border_bottom",   700,  884, 1'b1, 12'hFFF);
        applyStimulus("inside_bottom",   700,  883, 1'b1, 12'h000);
        applyStimulus("blank_no_video",  5,    500, 1'b0, 12'h000);

        setSeg(22, 400, 400);
        length = LW'(31);
        applyStimulus("length_clamped",  410, 410, 1'b1, 12'h0F0);
        length = LW'(22);
        applyStimulus("last_seg_hidden", 410, 410, 1'b1, 12'h000);

        // Back-to-back scan across head, body, apple with gaps in video.
        length = LW'(2);
        for (int x = 190; x < 320; x++) begin
            @(negedge clk);
            curr_x    = CW'(x);
            curr_y    = CW'(x < 260 ? 215 : 305);
            pix_valid = (x % 7) != 0;
        end

        // Outcome arrives mid-frame: nothing changes until frame_start.
        win  = 1'b1;
        lose = 1'b1;
        applyStimulus("before_frame_start", 700, 500, 1'b1, 12'h000);
        pulseFrame();
        applyStimulus("lose_frame0", 700, 500, 1'b1, 12'hF00);
        pulseFrame();
        applyStimulus("lose_frame1", 700, 500, 1'b1, 12'hF00);
        pulseFrame();
        applyStimulus("lose_frame2", 700, 500, 1'b1, 12'h000);
        pulseFrame();
        applyStimulus("lose_frame3", 310, 310, 1'b1, 12'h000);
        pulseFrame();
        applyStimulus("lose_frame4", 700, 500, 1'b1, 12'hF00);
        lose = 1'b0;
        pulseFrame();
        applyStimulus("lose_sticky",  700, 500, 1'b1, 12'hF00);
        applyStimulus("lose_blanked", 700, 500, 1'b0, 12'h000);

        // Reset while pixels stream.
        win  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            curr_x    = CW'(305 + k);
            curr_y    = CW'(310);
            pix_valid = 1'b1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_midstream", 12'h000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("after_reset_play", 310, 310, 1'b1, 12'hF00);

        win = 1'b1;
        pulseFrame();
        applyStimulus("win_frame0", 700, 500, 1'b1, 12'h0F0);
        pulseFrame();
        applyStimulus("win_frame1", 310, 310, 1'b1, 12'h0F0);
        pulseFrame();
        applyStimulus("win_frame2", 700, 500, 1'b1, 12'h000);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
